// File: rtl/ddr_arb_pkg.sv
// Shared encodings, default widths and helpers for the DDR write-port arbiter.
// Optional watchdog is enabled with the ARB_WDOG_EN macro.
package ddr_arb_pkg;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_GRANT   = 2'd1;
  localparam logic [1:0] ARB_BUSY    = 2'd2;
  localparam logic [1:0] ARB_RELEASE = 2'd3;

  localparam int DEF_NREQ    = 2;
  localparam int DEF_DW      = 512;
  localparam int DEF_AW      = 30;
  localparam int DEF_BW      = 5;
  localparam int DEF_TIMEOUT = 4096;
  localparam int IDX_W       = $clog2(DEF_NREQ);

  function automatic int idx_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // True while a requester owns the port (ack asserted).
  function automatic logic is_granted_state(input logic [1:0] st);
    return (st == ARB_GRANT) || (st == ARB_BUSY);
  endfunction

endpackage

// File: rtl/ddr_wr_arbiter_if.sv
// Requester-side and DDR-side signal bundle of the DDR write-port arbiter.
// The arbiter uses the slave modport; the requesters/DDR model use master.
interface ddr_wr_arbiter_if #(
  parameter int NREQ = 2,
  parameter int DW   = 512,
  parameter int AW   = 30,
  parameter int BW   = 5
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    ack_o;
  logic [NREQ-1:0]    req_wr_en_i;
  logic [NREQ*BW-1:0] req_burst_num_i;
  logic [NREQ*AW-1:0] req_start_addr_i;
  logic [NREQ*DW-1:0] req_wr_data_i;
  logic [NREQ-1:0]    req_fetch_en_o;
  logic [NREQ-1:0]    req_wr_done_o;
  logic               wr_ddr_en_o;
  logic [BW-1:0]      wr_burst_num_o;
  logic [AW-1:0]      wr_start_addr_o;
  logic [DW-1:0]      wr_data_o;
  logic               fetch_data_en_i;
  logic               wr_ddr_done_i;
  logic               busy_o;
  logic               wdog_err_o;

  modport slave (
    input  req_i, req_wr_en_i, req_burst_num_i, req_start_addr_i, req_wr_data_i,
    input  fetch_data_en_i, wr_ddr_done_i,
    output ack_o, req_fetch_en_o, req_wr_done_o,
    output wr_ddr_en_o, wr_burst_num_o, wr_start_addr_o, wr_data_o,
    output busy_o, wdog_err_o
  );

  modport master (
    output req_i, req_wr_en_i, req_burst_num_i, req_start_addr_i, req_wr_data_i,
    output fetch_data_en_i, wr_ddr_done_i,
    input  ack_o, req_fetch_en_o, req_wr_done_o,
    input  wr_ddr_en_o, wr_burst_num_o, wr_start_addr_o, wr_data_o,
    input  busy_o, wdog_err_o
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    int w_j;
    o_valid = 1'b0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j     = int'(i_ptr) + k;
      w_j     = (w_j >= NREQ) ? (w_j - NREQ) : w_j;
      o_valid = o_valid | i_req[w_j];
      o_idx   = i_req[w_j] ? IDX_W'(w_j) : o_idx;
    end
  end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter sharing one DDR write port among NREQ requesters.
// Define ARB_WDOG_EN to add the grant watchdog (wdog_err_o, forced release).
module ddr_wr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DW      = DEF_DW,
  parameter int AW      = DEF_AW,
  parameter int BW      = DEF_BW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic              clk_i,
  input logic              rst_i,
  ddr_wr_arbiter_if.slave  bus
);

  localparam int IW = idx_width(NREQ);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [IW-1:0]   r_gnt_idx;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   w_pick_idx;
  logic [IW-1:0]   w_next_gnt;
  logic [IW-1:0]   w_ptr_inc;
  logic            w_pick_valid;
  logic            w_req_g;
  logic            w_wren_g;
  logic            w_wdog_fire;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] w_ack_next;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IW)
  ) u_rr_pick (
    .i_req   (bus.req_i),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  assign w_req_g  = bus.req_i[r_gnt_idx];
  assign w_wren_g = bus.req_wr_en_i[r_gnt_idx];

  // Next-state logic; the watchdog overrides every other transition.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) w_next_state = ARB_GRANT;
        else              w_next_state = ARB_IDLE;
      end
      ARB_GRANT: begin
        if (w_wdog_fire)   w_next_state = ARB_RELEASE;
        else if (w_wren_g) w_next_state = ARB_BUSY;
        else if (!w_req_g) w_next_state = ARB_RELEASE;
        else               w_next_state = ARB_GRANT;
      end
      ARB_BUSY: begin
        if (w_wdog_fire || bus.wr_ddr_done_i) w_next_state = ARB_RELEASE;
        else                                  w_next_state = ARB_BUSY;
      end
      ARB_RELEASE: w_next_state = ARB_IDLE;
      default:     w_next_state = ARB_IDLE;
    endcase
  end

  // Grant index for the coming cycle, pointer successor and registered one-hot ack.
  always_comb begin
    w_next_gnt = (r_state == ARB_IDLE) ? w_pick_idx : r_gnt_idx;
    if (int'(r_gnt_idx) >= NREQ - 1) w_ptr_inc = '0;
    else                             w_ptr_inc = r_gnt_idx + IW'(1);
    w_ack_next = '0;
    if (is_granted_state(w_next_state)) w_ack_next[w_next_gnt] = 1'b1;
    else                                w_ack_next = '0;
  end

  // Arbiter state, latched grant, round-robin pointer and ack register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ARB_IDLE;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
      r_ack     <= '0;
    end else begin
      r_state   <= w_next_state;
      r_gnt_idx <= w_next_gnt;
      r_ack     <= w_ack_next;
      if (r_state == ARB_RELEASE) r_ptr <= w_ptr_inc;
      else                        r_ptr <= r_ptr;
    end
  end

  // DDR-side mux and return-path routing, live only while a burst is in flight.
  always_comb begin
    bus.wr_ddr_en_o     = 1'b0;
    bus.wr_burst_num_o  = '0;
    bus.wr_start_addr_o = '0;
    bus.wr_data_o       = '0;
    bus.req_fetch_en_o  = '0;
    bus.req_wr_done_o   = '0;
    if (r_state == ARB_BUSY) begin
      bus.wr_ddr_en_o                = w_wren_g;
      bus.wr_burst_num_o             = bus.req_burst_num_i[int'(r_gnt_idx)*BW +: BW];
      bus.wr_start_addr_o            = bus.req_start_addr_i[int'(r_gnt_idx)*AW +: AW];
      bus.wr_data_o                  = bus.req_wr_data_i[int'(r_gnt_idx)*DW +: DW];
      bus.req_fetch_en_o[r_gnt_idx]  = bus.fetch_data_en_i;
      bus.req_wr_done_o[r_gnt_idx]   = bus.wr_ddr_done_i;
    end else begin
      bus.wr_ddr_en_o     = 1'b0;
      bus.req_fetch_en_o  = '0;
      bus.req_wr_done_o   = '0;
    end
  end

  assign bus.ack_o  = r_ack;
  assign bus.busy_o = (r_state != ARB_IDLE);

`ifdef ARB_WDOG_EN
  logic [15:0] r_wdog_cnt;
  logic        r_wdog_err;

  assign w_wdog_fire = is_granted_state(r_state) && (r_wdog_cnt == 16'(TIMEOUT - 1));

  // Watchdog counts cycles spent in one grant state; the error flag is sticky.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wdog_cnt <= 16'd0;
      r_wdog_err <= 1'b0;
    end else begin
      if (w_next_state != r_state)     r_wdog_cnt <= 16'd0;
      else if (is_granted_state(r_state)) r_wdog_cnt <= r_wdog_cnt + 16'd1;
      else                             r_wdog_cnt <= 16'd0;
      if (w_wdog_fire) r_wdog_err <= 1'b1;
      else             r_wdog_err <= r_wdog_err;
    end
  end

  assign bus.wdog_err_o = r_wdog_err;
`else
  logic [15:0] w_unused_timeout;

  assign w_unused_timeout = 16'(TIMEOUT);
  assign w_wdog_fire      = 1'b0;
  assign bus.wdog_err_o   = 1'b0;
`endif

endmodule
